// File: rtl/data_mem_responder.sv
// Fixed-latency, single-outstanding data-memory slave for the Memory stage.
// It accepts one read or write, waits LATENCY cycles, then gives a one-cycle response.
module data_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        misaligned;
    logic [AW-1:0] word_idx;

    logic [15:0] mem_q [MEM_WORDS];
    logic [15:0] hold_rdata_q;
    logic        hold_err_q;
    logic [15:0] rsp_rdata_q;
    logic        rsp_err_q;

    // Upper address bits are dropped on purpose, so addresses wrap silently.
    generate
        if (AW < 15) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[15:AW+1];
        end
    endgenerate

    assign word_idx   = req_addr[AW:1];
    assign misaligned = req_addr[0];

    // Ready is a decode of state and reset only, so it never loops back through req_valid.
    assign req_ready = !rst && ((state_q == S_IDLE) || (state_q == S_RESP));
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q == S_WAIT);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            hold_rdata_q <= 16'd0;
            hold_err_q   <= 1'b0;
            rsp_rdata_q  <= 16'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Read data is snapshotted at acceptance, so a later write cannot alter it.
            if (accept) begin
                hold_rdata_q <= (req_wr || misaligned) ? 16'd0 : mem_q[word_idx];
                hold_err_q   <= misaligned;
            end
            if (state_d == S_RESP) begin
                rsp_rdata_q <= hold_rdata_q;
                rsp_err_q   <= hold_err_q;
            end else begin
                rsp_rdata_q <= 16'd0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= 16'd0;
            end
        end else if (accept && req_wr && !misaligned) begin
            mem_q[word_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=4 and one at LATENCY=2,
// both with 1024 words, sharing clock and reset.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_wr, rsp_valid, rsp_err, busy;
    logic [15:0] req_addr, req_wdata, rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_wr, b_rsp_valid, b_rsp_err, b_busy;
    logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(4), .MEM_WORDS(1024)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_responder #(.LATENCY(2), .MEM_WORDS(1024)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
    );

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request on the LATENCY=4 instance; returns in the RESP cycle (ready for back-to-back).
    task automatic req4(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        step();
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'd0; req_wdata = 16'd0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            n_checks++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_handshake: ready=%b busy=%b, required ready=0 busy=1", req_ready, busy);
            end
            step();
            lat++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        $display("txn L4 %s addr=%h wdata=%h -> rdata=%h err=%b edges=%0d",
                 wr ? "WR" : "RD", addr, wdata, rdata, err, lat);
    endtask

    task automatic test_reset();
        logic [15:0] rd; logic er; int lat;
        rst = 1'b1;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0010; req_wdata = 16'hFFFF;
        b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 16'h0010; b_req_wdata = 16'hFFFF;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: ready=%b rsp_valid=%b busy=%b, required 0 0 0", req_ready, rsp_valid, busy);
            end
            n_checks++;
            if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0 || b_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs_l2: ready=%b rsp_valid=%b busy=%b, required 0 0 0", b_req_ready, b_rsp_valid, b_busy);
            end
        end
        rst = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'd0; req_wdata = 16'd0;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = 16'd0; b_req_wdata = 16'd0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: ready=%b ready_l2=%b, required 1 1", req_ready, b_req_ready);
        end
        req4(1'b0, 16'h0010, 16'h0000, rd, er, lat);
        n_checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: rdata=%h err=%b, required 0000 0", rd, er);
        end
        step();
    endtask

    task automatic test_write_read();
        logic [15:0] rd; logic er; int lat;
        req4(1'b1, 16'h0020, 16'hBEEF, rd, er, lat);
        n_checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL write_rsp: rdata=%h err=%b, required 0000 0", rd, er);
        end
        // Three WAIT edges after acceptance; RESP is the fourth cycle, sampled at edge 4.
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL write_latency: edges=%0d, required 3", lat);
        end
        req4(1'b0, 16'h0020, 16'h0000, rd, er, lat);
        n_checks++;
        if (rd !== 16'hBEEF || er !== 1'b0 || lat !== 3) begin
            n_fail++;
            $display("FAIL read_after_write: rdata=%h err=%b edges=%0d, required BEEF 0 3", rd, er, lat);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: rsp_valid=%b rdata=%h busy=%b, required 0 0000 0", rsp_valid, rsp_rdata, busy);
        end
    endtask

    task automatic test_misaligned();
        logic [15:0] rd; logic er; int lat;
        req4(1'b1, 16'h0021, 16'h1234, rd, er, lat);
        n_checks++;
        if (rd !== 16'h0000 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_rsp: rdata=%h err=%b, required 0000 1", rd, er);
        end
        req4(1'b0, 16'h0020, 16'h0000, rd, er, lat);
        n_checks++;
        if (rd !== 16'hBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL misaligned_no_write: rdata=%h err=%b, required BEEF 0", rd, er);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [15:0] rd; logic er; int lat;
        req4(1'b1, 16'h0802, 16'hA5A5, rd, er, lat);
        req4(1'b0, 16'h0002, 16'h0000, rd, er, lat);
        n_checks++;
        if (rd !== 16'hA5A5 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_read: rdata=%h err=%b, required A5A5 0", rd, er);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd; logic er; int lat; int seen;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0020; req_wdata = 16'd0;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy=%b rsp_valid=%b ready=%b, required 0 0 0", busy, rsp_valid, req_ready);
        end
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
            step();
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_orphan: %0d cycles with rsp_valid/busy, required 0", seen);
        end
        $display("txn L4 RD addr=0020 discarded by reset");
        req4(1'b0, 16'h0020, 16'h0000, rd, er, lat);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_clear_20: rdata=%h, required 0000", rd);
        end
        req4(1'b0, 16'h0002, 16'h0000, rd, er, lat);
        n_checks++;
        if (rd !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_clear_02: rdata=%h, required 0000", rd);
        end
        step();
    endtask

    // LATENCY=2 instance: 8 back-to-back writes then 8 back-to-back reads, req_valid held high.
    task automatic test_back_to_back();
        logic [15:0] exp_data [8];
        for (int k = 0; k < 8; k++) exp_data[k] = 16'h1000 + 16'(k * 16'h0111);
        for (int pass = 0; pass < 2; pass++) begin
            b_req_valid = 1'b1;
            b_req_wr    = (pass == 0);
            b_req_addr  = 16'h0040;
            b_req_wdata = exp_data[0];
            for (int k = 0; k < 8; k++) begin
                step();
                n_checks++;
                if (b_busy !== 1'b1 || b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_wait[%0d]: busy=%b ready=%b rsp_valid=%b, required 1 0 0", k, b_busy, b_req_ready, b_rsp_valid);
                end
                step();
                n_checks++;
                if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0 ||
                    b_rsp_rdata !== ((pass == 0) ? 16'h0000 : exp_data[k])) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d] pass %0d: valid=%b err=%b rdata=%h, required 1 0 %h", k, pass,
                             b_rsp_valid, b_rsp_err, b_rsp_rdata, (pass == 0) ? 16'h0000 : exp_data[k]);
                end
                $display("txn L2 %s addr=%h -> rdata=%h", (pass == 0) ? "WR" : "RD", b_req_addr, b_rsp_rdata);
                if (k < 7) begin
                    b_req_addr  = 16'h0040 + 16'(2 * (k + 1));
                    b_req_wdata = exp_data[k + 1];
                end else begin
                    b_req_valid = 1'b0;
                end
            end
            step();
            n_checks++;
            if (b_rsp_valid !== 1'b0 || b_busy !== 1'b0 || b_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_idle pass %0d: rsp_valid=%b busy=%b ready=%b, required 0 0 1", pass, b_rsp_valid, b_busy, b_req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
